// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor with an in-order queue of in-flight predictions.
// Latency: prediction 1 cycle after accept; mispredict pulse 1 cycle after resolve.
// Backpressure: ready drops while FIFO_DEPTH predictions are unresolved; refused branches are dropped.

// Generic single-clock FIFO holding in-flight entries.
// Latency: pushed data visible at the read port the cycle after the push edge.
// Backpressure: push_rdy_o low when full; pop ignored when empty.
module gshare_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  output logic         push_rdy_o,
  input  logic         pop_rdy_i,
  output logic         pop_vld_o,
  output logic [W-1:0] pop_dat_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_fire;
  logic             pop_fire;

  assign push_rdy_o = (cnt_q != FULL_CNT);
  assign pop_vld_o  = (cnt_q != '0);
  assign pop_dat_o  = mem_q[rd_ptr_q];
  assign push_fire  = push_vld_i && push_rdy_o;
  assign pop_fire   = pop_rdy_i && pop_vld_o;

  // Next-state: write slot, advance pointers (power-of-2 depth wraps naturally), track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_fire && !pop_fire) begin
      cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (!push_fire && pop_fire) begin
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  // State registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Gshare predictor top: PHT of 2-bit counters indexed by addr XOR non-speculative history.
// Latency: pred_valid/prediction 1 cycle after accept; mispredict and counters 1 cycle after resolve.
// Backpressure: ready = queue not full; branch without ready is dropped, resolve on empty is ignored.
module gshare_predictor #(
  parameter int ADDR_W     = 11,
  parameter int HIST_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic              pred_valid,
  output logic              prediction,
  input  logic              resolve,
  input  logic              outcome,
  output logic              mispredict,
  output logic [CNT_W-1:0]  resolved_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);
  localparam int PHT_N  = 2 ** HIST_W;
  localparam int ENTRY_W = HIST_W + 1;

  // Table and history state
  logic [1:0]        pht_q [PHT_N];
  logic [1:0]        pht_d [PHT_N];
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // Registered outputs
  logic              pred_valid_q, pred_valid_d;
  logic              prediction_q, prediction_d;
  logic              mispredict_q, mispredict_d;
  logic [CNT_W-1:0]  resolved_cnt_q, resolved_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  // Lookup / resolve datapath
  logic [HIST_W-1:0] lookup_idx;
  logic              lookup_pred;
  logic              accept;
  logic              fifo_rdy;
  logic              fifo_vld;
  logic              resolve_fire;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] pop_entry;
  logic [HIST_W-1:0] res_idx;
  logic              res_pred;
  logic              unused_addr_hi;

  // Only the low address bits feed the index; the rest are deliberately ignored.
  assign unused_addr_hi = ^addr[ADDR_W-1:HIST_W];

  assign lookup_idx   = addr[HIST_W-1:0] ^ ghr_q;
  assign lookup_pred  = pht_q[lookup_idx][1];
  assign accept       = branch && fifo_rdy;
  assign resolve_fire = resolve && fifo_vld;
  assign push_entry   = {lookup_idx, lookup_pred};
  assign res_idx      = pop_entry[ENTRY_W-1:1];
  assign res_pred     = pop_entry[0];

  // Each entry remembers which counter it read and what it predicted, so resolve trains the same slot.
  gshare_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_inflight (
    .clk_i      (clk),
    .rst_ni     (reset),
    .push_vld_i (branch),
    .push_dat_i (push_entry),
    .push_rdy_o (fifo_rdy),
    .pop_rdy_i  (resolve),
    .pop_vld_o  (fifo_vld),
    .pop_dat_o  (pop_entry)
  );

  // Counter training and history shift happen only on a real resolve; lookup this edge sees old values.
  always_comb begin
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (resolve_fire) begin
      if (outcome) begin
        if (pht_q[res_idx] != 2'b11) begin
          pht_d[res_idx] = pht_q[res_idx] + 2'd1;
        end
      end else begin
        if (pht_q[res_idx] != 2'b00) begin
          pht_d[res_idx] = pht_q[res_idx] - 2'd1;
        end
      end
      ghr_d = {ghr_q[HIST_W-2:0], outcome};
    end
  end

  // Output pulses and statistics; prediction holds its last value between requests.
  always_comb begin
    pred_valid_d   = accept;
    prediction_d   = prediction_q;
    mispredict_d   = 1'b0;
    resolved_cnt_d = resolved_cnt_q;
    mispred_cnt_d  = mispred_cnt_q;
    if (accept) begin
      prediction_d = lookup_pred;
    end
    if (resolve_fire) begin
      resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
      if (outcome != res_pred) begin
        mispredict_d  = 1'b1;
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset returns every counter to weak not-taken and clears history/statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= 2'b01;
      end
      ghr_q          <= '0;
      pred_valid_q   <= 1'b0;
      prediction_q   <= 1'b0;
      mispredict_q   <= 1'b0;
      resolved_cnt_q <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      pht_q          <= pht_d;
      ghr_q          <= ghr_d;
      pred_valid_q   <= pred_valid_d;
      prediction_q   <= prediction_d;
      mispredict_q   <= mispredict_d;
      resolved_cnt_q <= resolved_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign ready        = fifo_rdy;
  assign pred_valid   = pred_valid_q;
  assign prediction   = prediction_q;
  assign mispredict   = mispredict_q;
  assign resolved_cnt = resolved_cnt_q;
  assign mispred_cnt  = mispred_cnt_q;
endmodule
